// File: rtl/ofdm_tx_pkg.sv
// rtl/ofdm_tx_pkg.sv - shared rate encodings, code polynomials, frame lengths and FSM states for ofdm_bit_encoder
package ofdm_tx_pkg;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2,
        RATE_5_6 = 2'd3
    } code_rate_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVICE,
        ST_DATA,
        ST_TAIL,
        ST_FLUSH
    } enc_state_e;

    localparam logic [6:0] G0           = 7'o133;
    localparam logic [6:0] G1           = 7'o171;
    localparam logic [6:0] DEFAULT_SEED = 7'h5D;
    localparam int         SERVICE_LEN  = 16;
    localparam int         TAIL_LEN     = 6;

    function automatic logic [2:0] punc_period(input code_rate_e rate);
        case (rate)
            RATE_2_3: return 3'd2;
            RATE_3_4: return 3'd3;
            RATE_5_6: return 3'd5;
            default:  return 3'd1;
        endcase
    endfunction

    // {keep_a, keep_b} for the input bit at this phase; after phase 0 the patterns alternate A-only / B-only
    function automatic logic [1:0] punc_keep(input code_rate_e rate, input logic [2:0] phase);
        logic [1:0] keep;
        keep = 2'b11;
        if (phase != 3'd0 && rate != RATE_1_2)
            keep = phase[0] ? 2'b10 : 2'b01;
        return keep;
    endfunction

endpackage

// File: rtl/ofdm_bit_encoder_if.sv
// rtl/ofdm_bit_encoder_if.sv - byte input and coded-bit output handshakes of ofdm_bit_encoder
interface ofdm_bit_encoder_if;
    logic [7:0] byte_in;
    logic       byte_in_strobe;
    logic       byte_in_ready;
    logic       out_bit;
    logic       out_strobe;
    logic       out_ready;

    modport master (
        output byte_in, byte_in_strobe, out_ready,
        input  byte_in_ready, out_bit, out_strobe
    );

    modport slave (
        input  byte_in, byte_in_strobe, out_ready,
        output byte_in_ready, out_bit, out_strobe
    );
endinterface

// File: rtl/ofdm_bit_encoder_scramble.sv
// rtl/ofdm_bit_encoder_scramble.sv - x^7+x^4+1 additive scrambler, the mirror of descramble
module scramble
    import ofdm_tx_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic [6:0] i_seed,
    input  logic       i_advance,
    input  logic       i_bit,
    output logic       o_bit
);
    logic [6:0] r_state;
    logic       w_fb;

    assign w_fb  = r_state[6] ^ r_state[3];
    assign o_bit = i_bit ^ w_fb;

    // an all-zero state would lock up, so a zero seed falls back to the default
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= '0;
        else if (i_load)
            r_state <= (i_seed == 7'd0) ? DEFAULT_SEED : i_seed;
        else if (i_advance)
            r_state <= {r_state[5:0], w_fb};
    end
endmodule

// File: rtl/ofdm_bit_encoder.sv
// rtl/ofdm_bit_encoder.sv - framed scrambler + K=7 convolutional encoder with puncturing
// rate 5/6 is accepted only when OFDM_TX_CODE_RATE_5_6_EN is defined
module ofdm_bit_encoder
    import ofdm_tx_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_start,
    input  logic [1:0]        i_code_rate,
    input  logic              i_do_scramble,
    input  logic [6:0]        i_seed,
    input  logic [15:0]       i_num_data_bits,
    ofdm_bit_encoder_if.slave io_bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err
);
    enc_state_e r_state, w_next_state;
    code_rate_e r_rate;
    logic        r_scramble;
    logic [15:0] r_bits_left;
    logic [4:0]  r_cnt;
    logic [5:0]  r_enc;
    logic [2:0]  r_punc;
    logic        r_sub;
    logic [7:0]  r_byte;
    logic [2:0]  r_idx;
    logic        r_byte_valid;
    logic        r_out_valid, r_out_bit, r_done, r_cfg_err;

    logic        w_start_ok, w_rate_ok, w_launch, w_byte_ready, w_accept;
    logic [7:0]  w_byte;
    logic [2:0]  w_idx;
    logic        w_raw_bit, w_scr_bit, w_in_bit, w_have_bit;
    logic [6:0]  w_reg7;
    logic        w_a, w_b, w_slot, w_emit, w_advance, w_emit_bit, w_last_punc;
    logic [1:0]  w_keep;

`ifdef OFDM_TX_CODE_RATE_5_6_EN
    assign w_rate_ok = 1'b1;
`else
    assign w_rate_ok = (i_code_rate != RATE_5_6);
`endif

    assign w_start_ok   = i_enable && i_start && (r_state == ST_IDLE);
    assign w_launch     = w_start_ok && w_rate_ok;
    assign w_byte_ready = (r_state == ST_DATA) && !r_byte_valid && (r_bits_left != 16'd0);
    assign w_accept     = i_enable && w_byte_ready && io_bus.byte_in_strobe;

    // a byte arriving this cycle is used directly so byte boundaries cost no output cycle
    assign w_byte    = r_byte_valid ? r_byte : io_bus.byte_in;
    assign w_idx     = r_byte_valid ? r_idx : 3'd0;
    assign w_raw_bit = (r_state == ST_DATA) ? w_byte[w_idx] : 1'b0;
    assign w_in_bit  = (r_scramble && r_state != ST_TAIL) ? w_scr_bit : w_raw_bit;

    always_comb begin
        w_have_bit = 1'b0;
        case (r_state)
            ST_SERVICE, ST_TAIL: w_have_bit = 1'b1;
            ST_DATA:             w_have_bit = r_byte_valid || w_accept;
            default:             w_have_bit = 1'b0;
        endcase
    end

    assign w_reg7      = {w_in_bit, r_enc};
    assign w_a         = ^(w_reg7 & G0);
    assign w_b         = ^(w_reg7 & G1);
    assign w_keep      = punc_keep(r_rate, r_punc);
    assign w_last_punc = (r_punc == punc_period(r_rate) - 3'd1);
    assign w_slot      = !r_out_valid || io_bus.out_ready;
    assign w_emit      = i_enable && w_slot && w_have_bit;
    // an input bit retires once its last kept output (A or B) has been emitted
    assign w_advance   = w_emit && (r_sub || !w_keep[1] || !w_keep[0]);
    assign w_emit_bit  = (!r_sub && w_keep[1]) ? w_a : w_b;

    scramble u_scramble (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_launch),
        .i_seed    (i_seed),
        .i_advance (w_advance && r_scramble && (r_state == ST_SERVICE || r_state == ST_DATA)),
        .i_bit     (w_raw_bit),
        .o_bit     (w_scr_bit)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:
                if (w_launch)
                    w_next_state = i_do_scramble ? ST_SERVICE :
                                   (i_num_data_bits != 16'd0) ? ST_DATA : ST_TAIL;
            ST_SERVICE:
                if (w_advance && r_cnt == 5'(SERVICE_LEN - 1))
                    w_next_state = (r_bits_left != 16'd0) ? ST_DATA : ST_TAIL;
            ST_DATA:
                if (w_advance && r_bits_left == 16'd1)
                    w_next_state = ST_TAIL;
            ST_TAIL:
                if (w_advance && r_cnt == 5'(TAIL_LEN - 1))
                    w_next_state = ST_FLUSH;
            ST_FLUSH:
                if (i_enable && w_slot)
                    w_next_state = ST_IDLE;
            default:
                w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rate       <= RATE_1_2;
            r_scramble   <= 1'b0;
            r_bits_left  <= '0;
            r_cnt        <= '0;
            r_enc        <= '0;
            r_punc       <= '0;
            r_sub        <= 1'b0;
            r_byte       <= '0;
            r_idx        <= '0;
            r_byte_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_bit    <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (w_start_ok && !w_rate_ok)
                r_cfg_err <= 1'b1;
            if (w_launch) begin
                r_rate       <= code_rate_e'(i_code_rate);
                r_scramble   <= i_do_scramble;
                r_bits_left  <= i_num_data_bits;
                r_cnt        <= '0;
                r_enc        <= '0;
                r_punc       <= '0;
                r_sub        <= 1'b0;
                r_idx        <= '0;
                r_byte_valid <= 1'b0;
            end
            if (r_state == ST_FLUSH && i_enable && w_slot)
                r_done <= 1'b1;

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_bit   <= w_emit_bit;
            end else if (i_enable && w_slot) begin
                r_out_valid <= 1'b0;
            end

            if (w_emit && !w_advance)
                r_sub <= 1'b1;
            if (w_advance) begin
                r_sub  <= 1'b0;
                r_enc  <= {w_in_bit, r_enc[5:1]};
                r_punc <= w_last_punc ? 3'd0 : r_punc + 3'd1;
                r_cnt  <= (w_next_state != r_state) ? 5'd0 : r_cnt + 5'd1;
            end

            if (r_state == ST_DATA) begin
                if (w_advance) begin
                    r_byte       <= w_byte;
                    r_idx        <= w_idx + 3'd1;
                    r_byte_valid <= (w_idx != 3'd7) && (r_bits_left != 16'd1);
                    r_bits_left  <= r_bits_left - 16'd1;
                end else if (w_accept) begin
                    r_byte       <= io_bus.byte_in;
                    r_idx        <= 3'd0;
                    r_byte_valid <= 1'b1;
                end
            end
        end
    end

    assign io_bus.byte_in_ready = w_byte_ready;
    assign io_bus.out_strobe    = r_out_valid && i_enable;
    assign io_bus.out_bit       = r_out_bit;
    assign o_busy               = (r_state != ST_IDLE);
    assign o_done               = r_done;
    assign o_cfg_err            = r_cfg_err;
endmodule

// File: tb/tb_ofdm_bit_encoder.sv
// tb/tb_ofdm_bit_encoder.sv - self-checking bench for ofdm_bit_encoder (honours OFDM_TX_CODE_RATE_5_6_EN)
module tb_ofdm_bit_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  code_rate = 2'd0;
    logic        do_scramble = 1'b0;
    logic [6:0]  seed = 7'd0;
    logic [15:0] num_bits = 16'd0;
    logic        busy, done, cfg_err;

    ofdm_bit_encoder_if bus();

    ofdm_bit_encoder dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_enable        (enable),
        .i_start         (start),
        .i_code_rate     (code_rate),
        .i_do_scramble   (do_scramble),
        .i_seed          (seed),
        .i_num_data_bits (num_bits),
        .io_bus          (bus),
        .o_busy          (busy),
        .o_done          (done),
        .o_cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    bit         exp_q[$];
    bit         in_q[$];
    logic [7:0] byte_q[$];
    int         got_cnt = 0;
    int         done_cnt = 0;
    bit         chk_en = 1'b0;
    bit         stall_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: whole-frame bit list from the frame rules, then mother code and a puncture mask string
    function automatic void build_model(input bit scr, input int rate, input logic [6:0] sd,
                                        input int n, input logic [7:0] bytes[$]);
        bit         u[$];
        bit         d[7];
        bit         fb, b, a, bb;
        logic [6:0] s;
        string      pat;
        s = (sd == 7'd0) ? 7'h5D : sd;
        if (scr)
            for (int i = 0; i < 16; i++) begin
                fb = s[6] ^ s[3]; s = {s[5:0], fb}; u.push_back(fb);
            end
        for (int i = 0; i < n; i++) begin
            b = bytes[i / 8][i % 8];
            if (scr) begin
                fb = s[6] ^ s[3]; s = {s[5:0], fb}; b = b ^ fb;
            end
            u.push_back(b);
        end
        for (int i = 0; i < 6; i++) u.push_back(1'b0);
        case (rate)
            1:       pat = "1110";
            2:       pat = "111001";
            3:       pat = "1110011001";
            default: pat = "11";
        endcase
        exp_q.delete();
        for (int i = 0; i < u.size(); i++) begin
            for (int k = 0; k < 7; k++) d[k] = (i >= k) ? u[i - k] : 1'b0;
            a  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
            bb = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[6];
            if (pat[(2 * i) % pat.len()] == "1")     exp_q.push_back(a);
            if (pat[(2 * i + 1) % pat.len()] == "1") exp_q.push_back(bb);
        end
        in_q = u;
    endfunction

    initial begin
        bit prev_stall;
        bit prev_bit;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (prev_stall && enable && rst_n) begin
                    check("hold_strobe", bus.out_strobe, 1);
                    check("hold_bit", bus.out_bit, prev_bit);
                end
                if (!enable) check("no_strobe_disabled", bus.out_strobe, 0);
                if (bus.out_strobe && bus.out_ready) begin
                    if (got_cnt < exp_q.size()) check($sformatf("coded_bit_%0d", got_cnt), bus.out_bit, exp_q[got_cnt]);
                    else check("extra_strobe", bus.out_strobe, 0);
                    got_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    check("done_after_last", got_cnt, exp_q.size());
                end
                prev_stall = bus.out_strobe && !bus.out_ready && enable && rst_n;
                prev_bit   = bus.out_bit;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        bit take;
        bus.byte_in = 8'h00;
        bus.byte_in_strobe = 1'b0;
        forever begin
            @(negedge clk);
            take = bus.byte_in_strobe && bus.byte_in_ready && enable && rst_n;
            @(posedge clk); #2;
            if (take && byte_q.size() > 0) void'(byte_q.pop_front());
            bus.byte_in_strobe = (byte_q.size() > 0);
            bus.byte_in = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic run_frame(input string tag, input bit scr, input logic [1:0] rate, input logic [6:0] sd,
                             input int n, input bit stall, input int abort_at, input bit poke);
        logic [7:0] bq[$];
        int cyc;
        bq = byte_q;
        build_model(scr, int'(rate), sd, n, bq);
        got_cnt = 0; done_cnt = 0; stall_en = stall; chk_en = 1'b1;
        @(posedge clk); #3;
        start = 1'b1; do_scramble = scr; code_rate = rate; seed = sd; num_bits = n[15:0];
        @(posedge clk); #3;
        start = 1'b0; do_scramble = ~scr; seed = ~sd; num_bits = 16'hFFFF; code_rate = rate ^ 2'd1;
        check({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000 && !(abort_at > 0 && got_cnt >= abort_at)) begin
            @(posedge clk); #3;
            cyc++;
            if (poke && cyc == 8)  start = 1'b1;
            if (poke && cyc == 9)  start = 1'b0;
            if (poke && cyc == 12) enable = 1'b0;
            if (poke && cyc == 15) enable = 1'b1;
        end
        if (abort_at > 0) begin
            rst_n = 1'b0;
            while (exp_q.size() > got_cnt) void'(exp_q.pop_back());
            byte_q.delete();
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check({tag, "_abort_strobe"}, bus.out_strobe, 0);
                check({tag, "_abort_busy"}, busy, 0);
            end
            check({tag, "_abort_count"}, got_cnt, abort_at);
            @(posedge clk); #3;
            rst_n = 1'b1;
        end else begin
            check({tag, "_done_seen"}, done_cnt, 1);
            check({tag, "_count"}, got_cnt, exp_q.size());
            @(negedge clk);
            check({tag, "_done_one_cycle"}, done, 0);
            check({tag, "_idle"}, busy, 0);
            check({tag, "_bytes_used"}, byte_q.size(), 0);
        end
        chk_en = 1'b0;
        stall_en = 1'b0;
    endtask

    initial begin
        logic [7:0]  head;
        logic [10:0] svc;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_strobe", bus.out_strobe, 0);
        check("rst_bit", bus.out_bit, 0);
        check("rst_ready", bus.byte_in_ready, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        byte_q = '{8'h0B, 8'hF1, 8'h00};
        run_frame("sig_half", 1'b0, 2'd0, 7'h00, 18, 1'b0, 0, 1'b1);
        check("pin_sig_len", exp_q.size(), 48);
        head = '0;
        for (int i = 0; i < 8; i++) head = {head[6:0], exp_q[i]};
        check("pin_sig_head", head, 8'hEB);

        byte_q = '{8'h00};
        run_frame("svc_half", 1'b1, 2'd0, 7'h7F, 8, 1'b0, 0, 1'b0);
        check("pin_svc_len", exp_q.size(), 60);
        svc = '0;
        for (int i = 0; i < 11; i++) svc = {svc[9:0], in_q[i]};
        check("pin_svc_scrambled", svc, 11'b00001110111);

        byte_q = '{8'hA5};
        run_frame("r34", 1'b1, 2'd2, 7'h05, 8, 1'b0, 0, 1'b0);
        check("pin_r34_len", exp_q.size(), 40);

        byte_q = '{8'hA5};
        run_frame("r34_stall", 1'b1, 2'd2, 7'h05, 8, 1'b1, 0, 1'b0);

        run_frame("r23_empty", 1'b0, 2'd1, 7'h00, 0, 1'b0, 0, 1'b0);
        check("pin_r23_empty_len", exp_q.size(), 9);

        byte_q = '{8'hFF};
        run_frame("r34_partial", 1'b1, 2'd2, 7'h00, 4, 1'b0, 0, 1'b0);
        check("pin_r34_partial_len", exp_q.size(), 35);

        byte_q = '{8'h0B, 8'hF1, 8'h00};
        run_frame("abort", 1'b0, 2'd0, 7'h00, 18, 1'b0, 20, 1'b0);
        byte_q = '{8'h0B, 8'hF1, 8'h00};
        run_frame("after_abort", 1'b0, 2'd0, 7'h00, 18, 1'b1, 0, 1'b0);
        check("pin_after_abort_len", exp_q.size(), 48);

`ifdef OFDM_TX_CODE_RATE_5_6_EN
        byte_q = '{8'h3C, 8'h02};
        run_frame("r56", 1'b1, 2'd3, 7'h11, 10, 1'b0, 0, 1'b0);
        check("pin_r56_len", exp_q.size(), 39);
`else
        @(posedge clk); #3;
        start = 1'b1; code_rate = 2'd3; do_scramble = 1'b0; num_bits = 16'd8;
        @(posedge clk); #3;
        start = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        @(negedge clk);
        check("cfg_err_single", cfg_err, 0);
        check("cfg_err_idle", busy, 0);
        check("cfg_err_no_strobe", bus.out_strobe, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end
endmodule

// File: doc/ofdm_bit_encoder.md
OFDM_BIT_ENCODER -- requirements
Module: ofdm_bit_encoder

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (low = reset).
REQ-003 SHALL have port enable, input, 1; when low, all state holds and no strobe is asserted.
REQ-004 SHALL have port start, input, 1; a one-cycle pulse latches the frame parameters.
REQ-005 SHALL have port code_rate, input, 2; 0=1/2, 1=2/3, 2=3/4, 3=5/6; latched on start.
REQ-006 SHALL have port do_scramble, input, 1; 1=DATA (service+scramble), 0=SIG/HT-SIG; latched on start.
REQ-007 SHALL have port seed, input, 7; scrambler initial state, latched on start.
REQ-008 SHALL have port num_data_bits, input, 16; payload bit count, latched on start.
REQ-009 SHALL have ports byte_in (input, 8), byte_in_strobe (input, 1) and byte_in_ready (output, 1); byte accepted when strobe&ready.
REQ-010 SHALL have ports out_bit (output, 1) and out_strobe (output, 1), one coded bit per strobe, plus out_ready (input, 1) for backpressure.
REQ-011 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and cfg_err (output, 1, one-cycle pulse).

Function
REQ-012 SHALL implement FSM IDLE->SERVICE->DATA->TAIL->FLUSH->IDLE; SERVICE is skipped when do_scramble=0.
REQ-013 SHALL, in SERVICE, feed 16 zero bits through the scrambler.
REQ-014 SHALL, in DATA, consume num_data_bits bits LSB-first from bytes; unused bits of the final partial byte are discarded.
REQ-015 SHALL, in TAIL, feed 6 unscrambled zero bits; scrambler state is not advanced.
REQ-016 SHALL use scrambler x^7+x^4+1: fb=s[6]^s[3], s<={s[5:0],fb}, out=in^fb; seed 0 SHALL be replaced by 7'h5D; bypassed when do_scramble=0.
REQ-017 SHALL use K=7 convolutional code with g0=133o (A) and g1=171o (B); encoder register cleared on start.
REQ-018 SHALL emit per input bit A then B, deleting punctured bits: 2/3 keeps A1 B1 A2; 3/4 keeps A1 B1 A2 B3; 5/6 keeps A1 B1 A2 B3 A4 B5.
REQ-019 SHALL restart the puncture phase at 0 on start and SHALL NOT reset it between states.
REQ-020 SHALL hold out_bit and out_strobe stable while out_strobe=1 and out_ready=0; a bit completes on out_strobe&out_ready.
REQ-021 SHALL sustain one coded bit per cycle while out_ready=1; first out_strobe no later than 3 cycles after start.
REQ-022 SHALL assert byte_in_ready only in DATA when the current byte is exhausted; a strobe without ready is ignored.
REQ-023 SHALL pulse done one cycle after the last coded bit transfers, then return to IDLE.
REQ-024 SHALL ignore start while busy=1; start with num_data_bits=0 still emits service (if any) and tail.
REQ-025 SHALL, when TAIL ends off a puncture period boundary, emit only the kept bits produced so far.

Reset
REQ-026 SHALL set on reset: FSM=IDLE, out_strobe=0, out_bit=0, byte_in_ready=0, busy=0, done=0, cfg_err=0, all registers 0.
REQ-027 SHALL abort any frame on reset mid-operation with no further strobes.

Configuration
REQ-028 SHALL support 5/6 puncturing when macro OFDM_TX_CODE_RATE_5_6_EN is defined.
REQ-029 SHALL, when OFDM_TX_CODE_RATE_5_6_EN is undefined, reject start with code_rate=3: remain IDLE and pulse cfg_err.

Structure
REQ-030 SHALL take code_rate encodings, G0/G1 polynomials, default seed 7'h5D, tail/service lengths and the FSM state type from shared package ofdm_tx_pkg.
REQ-031 SHALL place the scrambler in sub-module scramble, the mirror of descramble.

Verification
REQ-032 SHALL verify: do_scramble=0, rate 1/2, num_data_bits=18, bytes 0x0B,0xF1,0x00 -> 48 coded bits matching golden K=7 model, then done.
REQ-033 SHALL verify: do_scramble=1, seed=7'h7F, rate 1/2, 8 zero data bits -> scrambled service begins 0000111 0111 before encoding; 60 coded bits total.
REQ-034 SHALL verify: rate 3/4, do_scramble=1, 8 data bits (30 input bits) -> exactly 40 coded bits in A1 B1 A2 B3 order.
REQ-035 SHALL verify: out_ready toggled randomly at 50% -> bit sequence identical to the no-stall run, out_bit stable while stalled.
REQ-036 SHALL verify: reset low at coded bit 20 -> no strobes after, busy=0; new start yields a full correct frame.
REQ-037 SHALL verify: code_rate=3 without the macro -> cfg_err one pulse, busy stays 0; with the macro -> 5/6 output count matches model.
